// File: rtl/mch_fifo_pkg.sv
// mch_fifo_pkg: shared types and width helpers for the multi-channel sync FIFO.
//   ptr_w(depth) : read/write pointer width for a channel of 'depth' entries
//   lvl_w(depth) : occupancy width, one bit wider so 'depth' itself fits
//   chan_status_t: per-channel status bundle returned by mch_fifo_chan
package mch_fifo_pkg;

  // Status level field is sized for the largest supported DEPTH; the top
  // only consumes the low lvl_w(DEPTH) bits.
  localparam int LVL_MAX_W = 32;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                 full;
    logic                 empty;
    logic                 afull;
    logic                 aempty;
    logic                 ovf;
    logic                 unf;
    logic [LVL_MAX_W-1:0] level;
  } chan_status_t;

endpackage

// File: rtl/mch_fifo_chan.sv
// mch_fifo_chan: bookkeeping for one FIFO channel (no storage).
// Ports:
//   clk, hw_rst (async, high), sw_rst (sync clear)
//   wr_req / rd_req        : request already decoded for this channel
//   afull_value/aempty_value: shared thresholds
//   wptr / rptr            : entry pointers into this channel's storage slice
//   wr_acc / rd_acc        : request accepted this cycle
//   status                 : full/empty/almost/sticky flags and level
module mch_fifo_chan
  import mch_fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          hw_rst,
  input  logic          sw_rst,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic [AW-1:0] afull_value,
  input  logic [AW-1:0] aempty_value,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic          wr_acc,
  output logic          rd_acc,
  output chan_status_t  status
);

  logic [AW:0] lvl;
  logic        full, empty, ovf, unf;

  // Flags derive from the registered level only, so a same-cycle read never
  // frees a slot for a write and a same-cycle write never feeds a read.
  assign full   = (lvl == (AW+1)'(DEPTH));
  assign empty  = (lvl == '0);
  assign wr_acc = wr_req & ~full  & ~sw_rst;
  assign rd_acc = rd_req & ~empty & ~sw_rst;

  always_ff @(posedge clk or posedge hw_rst) begin
    if (hw_rst) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (sw_rst) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
      if (wr_req && full)  ovf <= 1'b1;
      if (rd_req && empty) unf <= 1'b1;
    end
  end

  always_comb begin
    status            = '0;
    status.full       = full;
    status.empty      = empty;
    status.afull      = (lvl >= {1'b0, afull_value});
    status.aempty     = (lvl <= {1'b0, aempty_value});
    status.ovf        = ovf;
    status.unf        = unf;
    status.level[AW:0] = lvl;
  end

endmodule

// File: rtl/mch_sync_fifo.sv
// mch_sync_fifo: N_CH independent FIFOs behind one write and one read port.
// Optional feature macro: MCH_FIFO_PARITY_EN (per-entry even parity,
//   adds par_inject input and parity_err output).
// Ports:
//   clk, hw_rst (async, high), sw_rst (sync clear)
//   wdata/write_enable/wr_ch, afull_value   : write side
//   read_enable/rd_ch, aempty_value         : read side
//   read_data/rd_valid                      : registered read result
//   wfull, rdempty, wr_almost_ful, rd_almost_empty, overflow, underflow: per channel
//   level                                   : packed per-channel occupancy
module mch_sync_fifo
  import mch_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int N_CH   = 4,
  parameter int CH_W   = $clog2(N_CH),
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   hw_rst,
  input  logic                   sw_rst,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   write_enable,
  input  logic [CH_W-1:0]        wr_ch,
  input  logic [AW-1:0]          afull_value,
  input  logic                   read_enable,
  input  logic [CH_W-1:0]        rd_ch,
  input  logic [AW-1:0]          aempty_value,
  output logic [DATA_W-1:0]      read_data,
  output logic                   rd_valid,
  output logic [N_CH-1:0]        wfull,
  output logic [N_CH-1:0]        rdempty,
  output logic [N_CH-1:0]        wr_almost_ful,
  output logic [N_CH-1:0]        rd_almost_empty,
  output logic [N_CH-1:0]        overflow,
  output logic [N_CH-1:0]        underflow,
  output logic [N_CH*(AW+1)-1:0] level
`ifdef MCH_FIFO_PARITY_EN
  ,
  input  logic                   par_inject,
  output logic                   parity_err
`endif
);

`ifdef MCH_FIFO_PARITY_EN
  localparam int EW = DATA_W + 1;
`else
  localparam int EW = DATA_W;
`endif

  logic [N_CH-1:0][AW-1:0] wptr_a, rptr_a;
  logic [N_CH-1:0]         wr_acc_a, rd_acc_a;
  chan_status_t            st [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic unused_lvl_hi;

    mch_fifo_chan #(.DEPTH(DEPTH), .AW(AW)) u_chan (
      .clk          (clk),
      .hw_rst       (hw_rst),
      .sw_rst       (sw_rst),
      .wr_req       (write_enable && (wr_ch == CH_W'(c))),
      .rd_req       (read_enable  && (rd_ch == CH_W'(c))),
      .afull_value  (afull_value),
      .aempty_value (aempty_value),
      .wptr         (wptr_a[c]),
      .rptr         (rptr_a[c]),
      .wr_acc       (wr_acc_a[c]),
      .rd_acc       (rd_acc_a[c]),
      .status       (st[c])
    );

    assign wfull[c]                 = st[c].full;
    assign rdempty[c]               = st[c].empty;
    assign wr_almost_ful[c]         = st[c].afull;
    assign rd_almost_empty[c]       = st[c].aempty;
    assign overflow[c]              = st[c].ovf;
    assign underflow[c]             = st[c].unf;
    assign level[c*(AW+1) +: AW+1]  = st[c].level[AW:0];
    // status level is sized for the widest DEPTH; upper bits are always 0 here
    assign unused_lvl_hi            = ^st[c].level[LVL_MAX_W-1:AW+1];
  end

  // Shared storage: channel c owns entries {c, ptr}
  logic [EW-1:0] mem [N_CH*DEPTH];
  logic [EW-1:0] wentry, rentry;
  logic [AW-1:0] wp, rp;
  logic          wr_any, rd_any;

  assign wp     = wptr_a[wr_ch];
  assign rp     = rptr_a[rd_ch];
  assign wr_any = |wr_acc_a;
  assign rd_any = |rd_acc_a;
  assign rentry = mem[{rd_ch, rp}];

`ifdef MCH_FIFO_PARITY_EN
  assign wentry = {(^wdata) ^ par_inject, wdata};
`else
  assign wentry = wdata;
`endif

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_any) mem[{wr_ch, wp}] <= wentry;
  end

  always_ff @(posedge clk or posedge hw_rst) begin
    if (hw_rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
`ifdef MCH_FIFO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (sw_rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
`ifdef MCH_FIFO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_any;
      if (rd_any) read_data <= rentry[DATA_W-1:0];
`ifdef MCH_FIFO_PARITY_EN
      parity_err <= rd_any && ((^rentry[DATA_W-1:0]) != rentry[DATA_W]);
`endif
    end
  end

endmodule
